mult_ctrl_fsm: RTL

MULT_CTRL_FSM -- requirements
Module: mult_ctrl_fsm

---
 rtl/mult_ctrl_pkg.sv | 6 +
 rtl/btn_edge.sv | 15 +
 rtl/mult_ctrl_fsm.sv | 88 ++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: state type and default sizing shared by the multiplier controller
package mult_ctrl_pkg;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DIGITS = 4;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for a debounced button level
//   clk, rst_n (async, active-low); btn level in; rise is high for the first cycle btn is high.
//   History resets to 1 so a button held through reset never fires.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);
   logic prev;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev <= 1'b1;
      else        prev <= btn;
   assign rise = btn & ~prev;
endmodule

// File: rtl/mult_ctrl_fsm.sv
// mult_ctrl_fsm: control FSM for a shift-add multiplier plus display window select
//   clk, rst_n (async, active-low); btn_l/btn_r/btn_c debounced button levels;
//   z_flag (multiplier == 0), b0 (multiplier LSB); load/add_en/shift_en datapath strobes;
//   busy (LOAD/RUN), done (DONE); sel display window; iter completed iterations.
//   Define SEL_WRAP_EN to make sel wrap around instead of saturating.
module mult_ctrl_fsm
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       btn_l,
   input  logic                       btn_r,
   input  logic                       btn_c,
   input  logic                       z_flag,
   input  logic                       b0,
   output logic                       load,
   output logic                       add_en,
   output logic                       shift_en,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DIGITS)-1:0]  sel,
   output logic [$clog2(WIDTH+1)-1:0] iter
);
   localparam int SW = $clog2(DIGITS);
   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [SW-1:0] SEL_MAX  = SW'(DIGITS - 1);
   localparam logic [IW-1:0] ITER_MAX = IW'(WIDTH);
   state_t        state, state_nxt;
   logic [IW-1:0] iter_nxt;
   logic [SW-1:0] sel_nxt;
   logic          l_edge, r_edge, c_edge, inc, dec;
   btn_edge u_l (.clk(clk), .rst_n(rst_n), .btn(btn_l), .rise(l_edge));
   btn_edge u_r (.clk(clk), .rst_n(rst_n), .btn(btn_r), .rise(r_edge));
   btn_edge u_c (.clk(clk), .rst_n(rst_n), .btn(btn_c), .rise(c_edge));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         iter  <= '0;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         iter  <= iter_nxt;
         sel   <= sel_nxt;
      end
   // The last shifting iteration goes straight to DONE so the full run fits in WIDTH+2 cycles.
   always_comb begin
      state_nxt = state;
      iter_nxt  = iter;
      load      = 1'b0;
      add_en    = 1'b0;
      shift_en  = 1'b0;
      busy      = state == LOAD || state == RUN;
      done      = state == DONE;
      if (state == LOAD) begin
         load      = 1'b1;
         state_nxt = RUN;
      end
      if (state == RUN) begin
         if (z_flag) state_nxt = DONE;
         else begin
            add_en    = b0;
            shift_en  = 1'b1;
            iter_nxt  = iter + 1'b1;
            state_nxt = iter_nxt == ITER_MAX ? DONE : RUN;
         end
      end
      if (c_edge) begin
         state_nxt = LOAD;
         iter_nxt  = '0;
      end
   end
   // Simultaneous left and right edges cancel; a centre edge overrides both.
   always_comb begin
      inc = l_edge & ~r_edge;
      dec = r_edge & ~l_edge;
`ifdef SEL_WRAP_EN
      sel_nxt = inc ? (sel == SEL_MAX ? '0 : sel + 1'b1) :
                dec ? (sel == '0 ? SEL_MAX : sel - 1'b1) : sel;
`else
      sel_nxt = inc && sel != SEL_MAX ? sel + 1'b1 :
                dec && sel != '0      ? sel - 1'b1 : sel;
`endif
      if (c_edge) sel_nxt = '0;
   end
endmodule
